mmu_burst_initiator: RTL and testbench

//  Initiator side of the MMU port (address/we/data_in/data_out). Turns one burst command
//  (region, start index, length, direction) into a sequence of single-word MMU accesses.

---
 rtl/mmu_pkg.sv | 30 +++
 rtl/mmu_region_decode.sv | 37 +++
 rtl/mmu_burst_initiator.sv | 127 ++++++++++++
 tb/tb_mmu_burst_initiator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU address map: region encoding, base addresses, depths and the
// burst initiator FSM state type.
package mmu_pkg;

    localparam int MMU_ADDR_W   = 16;
    localparam int MMU_DATA_W   = 16;

    localparam int NEURON_DEPTH = 6;
    localparam int WEIGHT_DEPTH = 18;
    localparam int BIAS_DEPTH   = 7;

    localparam logic [15:0] NEURON_BASE = 16'h0000;
    localparam logic [15:0] WEIGHT_BASE = 16'h0100;
    localparam logic [15:0] BIAS_BASE   = 16'h0200;

    typedef enum logic [1:0] {
        REGION_NEURON  = 2'd0,
        REGION_WEIGHT  = 2'd1,
        REGION_BIAS    = 2'd2,
        REGION_ILLEGAL = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RD_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/mmu_region_decode.sv
// Combinational region decode: (region, start, len) -> base, depth, legal.
// MMU_ADDR_WRAP_EN: when defined, bursts running past the region end are
// legal (the index wraps to 0); otherwise start+len>depth is rejected.
module mmu_region_decode import mmu_pkg::*; #(
    parameter int ADDR_W = MMU_ADDR_W
) (
    input  logic [1:0]        region,
    input  logic [4:0]        start,
    input  logic [4:0]        len,
    output logic [ADDR_W-1:0] base,
    output logic [4:0]        depth,
    output logic              legal
);

    // look up base address and size of the addressed region
    always_comb begin
        base  = '0;
        depth = '0;
        case (region_e'(region))
            REGION_NEURON: begin base = ADDR_W'(NEURON_BASE); depth = 5'(NEURON_DEPTH); end
            REGION_WEIGHT: begin base = ADDR_W'(WEIGHT_BASE); depth = 5'(WEIGHT_DEPTH); end
            REGION_BIAS:   begin base = ADDR_W'(BIAS_BASE);   depth = 5'(BIAS_DEPTH);   end
            default:       ;
        endcase
    end

`ifdef MMU_ADDR_WRAP_EN
    // depth==0 for the illegal region, so start<depth also rejects it
    assign legal = (region != 2'd3) && (len != 5'd0) && (start < depth);
`else
    logic [5:0] span;
    assign span  = {1'b0, start} + {1'b0, len};
    assign legal = (region != 2'd3) && (len != 5'd0) && (start < depth) &&
                   (span <= {1'b0, depth});
`endif

endmodule

// File: rtl/mmu_burst_initiator.sv
// Burst initiator on the MMU port: one burst command becomes a run of
// single-word MMU accesses, fed by a write stream or drained to a read stream.
// MMU_ADDR_WRAP_EN (see mmu_region_decode) enables wrap-around bursts.
module mmu_burst_initiator import mmu_pkg::*; #(
    parameter int ADDR_W = MMU_ADDR_W,
    parameter int DATA_W = MMU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_region,
    input  logic [4:0]        cmd_start,
    input  logic [4:0]        cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    logic [ADDR_W-1:0] dec_base;
    logic [4:0]        dec_depth;
    logic              dec_legal;

    mmu_region_decode #(.ADDR_W(ADDR_W)) u_decode (
        .region (cmd_region),
        .start  (cmd_start),
        .len    (cmd_len),
        .base   (dec_base),
        .depth  (dec_depth),
        .legal  (dec_legal)
    );

    state_e            state;
    logic [4:0]        idx;
    logic [4:0]        count;
    logic [4:0]        depth_q;
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        idx_next;

    // next word index; the wrap is only reachable when wrap-around bursts
    // pass the legality check, otherwise bursts end before the region end
    always_comb begin
        idx_next = idx + 5'd1;
        if (idx_next == depth_q)
            idx_next = 5'd0;
    end

    // handshake outputs decode from state; reset blocks every handshake
    assign cmd_ready = (state == IDLE) && !rst;
    assign wr_ready  = (state == WR) && !rst;
    assign mem_we    = wr_ready && wr_valid;
    assign mem_wdata = wr_data;
    assign rd_valid  = (state == RD_OUT) && !rst;
    assign rd_data   = mem_rdata;
    assign busy      = (state != IDLE);

    // burst sequencer: accept/reject commands, step the address per word
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_addr <= '0;
            idx      <= '0;
            count    <= '0;
            depth_q  <= '0;
            base_q   <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (dec_legal) begin
                            base_q   <= dec_base;
                            depth_q  <= dec_depth;
                            idx      <= cmd_start;
                            count    <= cmd_len;
                            mem_addr <= dec_base + ADDR_W'(cmd_start);
                            state    <= cmd_write ? WR : RD_WAIT;
                        end else begin
                            // accepted and dropped
                            err <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        if (count == 5'd1) begin
                            state <= IDLE;
                        end else begin
                            idx      <= idx_next;
                            count    <= count - 5'd1;
                            mem_addr <= base_q + ADDR_W'(idx_next);
                        end
                    end
                end
                RD_WAIT: begin
                    // address held one cycle so the MMU registers data_out
                    state <= RD_OUT;
                end
                RD_OUT: begin
                    if (rd_ready) begin
                        if (count == 5'd1) begin
                            state <= IDLE;
                        end else begin
                            idx      <= idx_next;
                            count    <= count - 5'd1;
                            mem_addr <= base_q + ADDR_W'(idx_next);
                            state    <= RD_WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_burst_initiator.sv
// Bench for mmu_burst_initiator: behavioural MMU (1-cycle registered read),
// directed vector table, mid-burst reset sequence and random commands
// checked against an address-map model.
module tb_mmu_burst_initiator;

`ifdef MMU_ADDR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [1:0]  cmd_region = '0;
    logic [4:0]  cmd_start = '0, cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [15:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b0;
    logic [15:0] rd_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy, err;

    always #5 clk = ~clk;

    mmu_burst_initiator dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_region(cmd_region), .cmd_start(cmd_start), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    // behavioural MMU: registered read of the current address every cycle
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:0]];
    end

    // bench-side image of what the bench has written
    logic [15:0] ref_mem [0:1023];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // address-map model
    function automatic int depth_of(input int r);
        case (r)
            0: return 6;
            1: return 18;
            2: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int base_of(input int r);
        case (r)
            1: return 'h100;
            2: return 'h200;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal_of(input int r, input int s, input int l);
        return (r != 3) && (l != 0) && (s < depth_of(r)) && (WRAP || (s + l <= depth_of(r)));
    endfunction

    function automatic int addr_of(input int r, input int s, input int i);
        return base_of(r) + ((s + i) % depth_of(r));
    endfunction

    // issue one command and follow it to completion
    // write mode: 0 always valid, 1 pattern 1,0,0,1, 2 random
    // read mode:  0 always ready, 1 first word stalled 5 cycles, 2 random
    task automatic run_cmd(input bit wr, input int r, input int s, input int l,
                           input int mode, input bit exp_err, input int exp_first);
        int k, cyc, a;
        bit v, done;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_region = 2'(r);
        cmd_start  = 5'(s);
        cmd_len    = 5'(l);
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        if (exp_err) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_no_we", mem_we, 0);
            @(negedge clk);
            #1;
            chk("err_clear", err, 0);
            chk("err_no_we2", mem_we, 0);
        end else if (wr) begin
            k = 0;
            cyc = 0;
            while (k < l && cyc < 400) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                case (mode)
                    1: v = (cyc % 4 == 0) || (cyc % 4 == 3);
                    2: v = ($urandom_range(0, 2) != 0);
                    default: v = 1'b1;
                endcase
                wr_valid = v;
                wr_data  = 16'($urandom);
                #1;
                if (v) begin
                    a = (k == 0) ? exp_first : addr_of(r, s, k);
                    chk("wr_we", mem_we, 1);
                    chk("wr_addr", mem_addr, a);
                    chk("wr_data", mem_wdata, wr_data);
                    ref_mem[a[9:0]] = wr_data;
                    k++;
                end else begin
                    chk("wr_gap_no_we", mem_we, 0);
                end
                cyc++;
            end
            chk("wr_complete", k, l);
            @(negedge clk);
            wr_valid = 1'b0;
            #1;
            chk("wr_done_busy", busy, 0);
            chk("wr_done_err", err, 0);
        end else begin
            for (k = 0; k < l; k++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                rd_ready  = 1'b0;
                #1;
                chk("rd_wait_valid", rd_valid, 0);
                chk("rd_wait_busy", busy, 1);
                a = (k == 0) ? exp_first : addr_of(r, s, k);
                cyc = 0;
                done = 1'b0;
                while (!done && cyc < 60) begin
                    @(negedge clk);
                    case (mode)
                        1: v = !(k == 0 && cyc < 5);
                        2: v = ($urandom_range(0, 1) != 0);
                        default: v = 1'b1;
                    endcase
                    rd_ready = v;
                    #1;
                    chk("rd_valid", rd_valid, 1);
                    chk("rd_addr", mem_addr, a);
                    chk("rd_data", rd_data, ref_mem[a[9:0]]);
                    chk("rd_no_we", mem_we, 0);
                    if (v) done = 1'b1;
                    cyc++;
                end
                chk("rd_handshake", done, 1);
            end
            @(negedge clk);
            rd_ready = 1'b0;
            #1;
            chk("rd_done_busy", busy, 0);
            chk("rd_done_cmd_ready", cmd_ready, 1);
        end
    endtask

    typedef struct {
        bit wr;
        int region;
        int start;
        int len;
        int mode;
        bit exp_err;
        int exp_first;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b1, 1, 0, 18, 0, 1'b0, 'h100};  // full weight write
        vecs[1]  = '{1'b1, 0, 0, 6,  2, 1'b0, 'h000};  // fill neurons, random gaps
        vecs[2]  = '{1'b0, 0, 2, 3,  0, 1'b0, 'h002};  // read latency
        vecs[3]  = '{1'b0, 0, 0, 6,  1, 1'b0, 'h000};  // backpressure
        vecs[4]  = '{1'b1, 3, 0, 2,  0, 1'b1, 0};      // illegal region
        vecs[5]  = '{1'b1, 0, 1, 0,  0, 1'b1, 0};      // zero length
        if (WRAP) vecs[6] = '{1'b1, 2, 5, 3, 0, 1'b0, 'h205};
        else      vecs[6] = '{1'b1, 2, 5, 3, 0, 1'b1, 0};
        vecs[7]  = '{1'b0, 0, 6, 1,  0, 1'b1, 0};      // start == depth
        vecs[8]  = '{1'b1, 2, 0, 7,  1, 1'b0, 'h200};  // gapped write
        vecs[9]  = '{1'b0, 2, 0, 7,  2, 1'b0, 'h200};  // random stalls
        vecs[10] = '{1'b0, 1, 16, 2, 0, 1'b0, 'h110};  // last weight words
        if (WRAP) vecs[11] = '{1'b0, 2, 5, 3, 2, 1'b0, 'h205};
        else      vecs[11] = '{1'b0, 2, 5, 3, 0, 1'b1, 0};

        // reset state
        rst = 1'b1;
        wr_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_no_we", mem_we, 0);
        chk("rst_no_wr_ready", wr_ready, 0);
        chk("rst_no_rd_valid", rd_valid, 0);
        wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 12; i++)
            run_cmd(vecs[i].wr, vecs[i].region, vecs[i].start, vecs[i].len,
                    vecs[i].mode, vecs[i].exp_err, vecs[i].exp_first);

        // reset after 4 of 18 weight writes
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_region = 2'd1; cmd_start = 5'd0; cmd_len = 5'd18;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            wr_valid  = 1'b1;
            wr_data   = 16'($urandom);
            #1;
            chk("rstseq_we", mem_we, 1);
            chk("rstseq_addr", mem_addr, 'h100 + k);
            ref_mem[10'('h100 + k)] = wr_data;
        end
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b1;
        #1;
        chk("rstseq_we_gated", mem_we, 0);
        chk("rstseq_wr_ready_gated", wr_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("rstseq_idle", busy, 0);
        chk("rstseq_cmd_ready", cmd_ready, 1);
        chk("rstseq_addr", mem_addr, 0);

        // confirm the interrupted burst left words 0..3 and nothing else changed
        run_cmd(1'b0, 1, 0, 6, 0, 1'b0, 'h100);

        // random commands against the model
        for (int i = 0; i < 40; i++) begin
            bit w;
            int r, d, s, l, m;
            w = ($urandom_range(0, 1) != 0);
            r = $urandom_range(0, 3);
            d = depth_of(r);
            s = $urandom_range(0, d + 1);
            l = $urandom_range(0, (d == 0) ? 3 : d);
            m = $urandom_range(0, 2);
            run_cmd(w, r, s, l, m, !legal_of(r, s, l),
                    legal_of(r, s, l) ? addr_of(r, s, 0) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
